// File: rtl/u110_bus_arbiter.sv
// u110_bus_arbiter
//   Local-bus arbiter for the U110 68040 bus. The CPU is the parked default
//   master (BGn/BBn handshake). Up to four alternate masters request with
//   REQn[k] and are granted with GNTn[k], served round-robin.
//
// Ports
//   CLK40        in   system clock, rising edge
//   RESETn       in   asynchronous active-low reset
//   BRn          in   CPU bus request, active-low
//   BBn          in   bus busy, active-low (high = idle)
//   REQn[NREQ]   in   alternate-master requests, active-low
//   BGn          out  CPU bus grant, active-low
//   GNTn[NREQ]   out  alternate-master grants, active-low, at most one low
//   OWNER[3]     out  current grantee: 0 = CPU, k+1 = REQn[k]
//   ARB_TIMEOUT  out  one-cycle pulse when a grant is revoked for a missed BBn
//
// state   | meaning
// CPU_OWN | CPU parked/owning, BGn low
// CPU_REL | BGn withdrawn, waiting for the CPU to release BBn
// ALT_GNT | alternate master granted, waiting for it to assert BBn
// ALT_OWN | alternate master owns the bus
// ALT_REL | grant withdrawn, waiting for the master to release BBn
module u110_bus_arbiter #(
  parameter int NREQ          = 2,
  parameter int GRANT_TIMEOUT = 16,
  parameter int MAX_TENURE    = 64
) (
  input  logic            CLK40,
  input  logic            RESETn,
  input  logic            BRn,
  input  logic            BBn,
  input  logic [NREQ-1:0] REQn,
  output logic            BGn,
  output logic [NREQ-1:0] GNTn,
  output logic [2:0]      OWNER,
  output logic            ARB_TIMEOUT
);

  typedef enum logic [2:0] {CPU_OWN, CPU_REL, ALT_GNT, ALT_OWN, ALT_REL} state_t;

  localparam int CNT_MAX = (GRANT_TIMEOUT > MAX_TENURE) ? GRANT_TIMEOUT : MAX_TENURE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GT_LAST  = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] TEN_LAST = CW'(MAX_TENURE - 1);
  localparam logic [CW-1:0] TEN_SAT  = CW'(MAX_TENURE);
  localparam logic [NREQ-1:0] ALL_OFF = {NREQ{1'b1}};

  state_t          state_q, state_d;
  logic            bgn_q, bgn_d;
  logic [NREQ-1:0] gntn_q, gntn_d;
  logic [2:0]      owner_q, owner_d;
  logic            arb_timeout_q, arb_timeout_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            any_req;
  logic            arb_found;
  logic [1:0]      arb_win;
  logic [NREQ-1:0] arb_onehot;
  logic            hi_found;
  logic [1:0]      hi_win;
  logic [1:0]      lo_win;
  logic            own_rel;
  logic            other_req;

  // Round-robin pick: the lowest requester at or above rr_q wins, otherwise
  // the lowest requester overall (the wrap-around). The descending loop lets
  // the last assignment be the lowest index.
  always_comb begin
    any_req   = 1'b0;
    hi_found  = 1'b0;
    hi_win    = 2'd0;
    lo_win    = 2'd0;
    own_rel   = 1'b1;
    other_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (!REQn[i]) begin
        any_req = 1'b1;
        lo_win  = 2'(i);
        if (2'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_win   = 2'(i);
        end
        if (2'(i) != win_q) other_req = 1'b1;
      end
      if (2'(i) == win_q) own_rel = REQn[i];
    end
    arb_found = any_req;
    arb_win   = hi_found ? hi_win : lo_win;
    for (int i = 0; i < NREQ; i++) begin
      arb_onehot[i] = (2'(i) == arb_win);
    end
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= CPU_OWN;
      bgn_q         <= 1'b0;
      gntn_q        <= ALL_OFF;
      owner_q       <= 3'd0;
      arb_timeout_q <= 1'b0;
      rr_q          <= 2'd0;
      win_q         <= 2'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      bgn_q         <= bgn_d;
      gntn_q        <= gntn_d;
      owner_q       <= owner_d;
      arb_timeout_q <= arb_timeout_d;
      rr_q          <= rr_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bgn_d         = bgn_q;
    gntn_d        = gntn_q;
    owner_d       = owner_q;
    arb_timeout_d = 1'b0;
    rr_d          = rr_q;
    win_d         = win_q;
    cnt_d         = cnt_q;
    case (state_q)
      CPU_OWN: begin
        if (any_req) begin
          bgn_d   = 1'b1;
          state_d = CPU_REL;
        end
      end
      CPU_REL, ALT_REL: begin
        // Grants are only issued once BBn is seen idle.
        if (BBn) begin
          if (!arb_found || (state_q == ALT_REL && !BRn)) begin
            bgn_d   = 1'b0;
            owner_d = 3'd0;
            state_d = CPU_OWN;
          end else begin
            gntn_d  = ~arb_onehot;
            owner_d = 3'(arb_win) + 3'd1;
            rr_d    = (arb_win == 2'(NREQ - 1)) ? 2'd0 : arb_win + 2'd1;
            win_d   = arb_win;
            cnt_d   = '0;
            state_d = ALT_GNT;
          end
        end
      end
      ALT_GNT: begin
        // Timeout outranks a withdrawn request so the pulse is never lost.
        if (!BBn) begin
          cnt_d   = '0;
          state_d = ALT_OWN;
        end else if (cnt_q >= GT_LAST) begin
          gntn_d        = ALL_OFF;
          arb_timeout_d = 1'b1;
          state_d       = ALT_REL;
        end else if (own_rel) begin
          gntn_d  = ALL_OFF;
          state_d = ALT_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ALT_OWN: begin
        if (cnt_q != TEN_SAT) cnt_d = cnt_q + 1'b1;
        if (own_rel || (cnt_q >= TEN_LAST && (!BRn || other_req))) begin
          gntn_d  = ALL_OFF;
          state_d = ALT_REL;
        end
      end
      default: begin
        state_d = CPU_OWN;
        bgn_d   = 1'b0;
        gntn_d  = ALL_OFF;
        owner_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    BGn         = bgn_q;
    GNTn        = gntn_q;
    OWNER       = owner_q;
    ARB_TIMEOUT = arb_timeout_q;
  end

endmodule

// File: tb/tb_u110_bus_arbiter.sv
// tb_u110_bus_arbiter
//   Bench for u110_bus_arbiter (NREQ=2). Each test pushes the grantee it
//   expects next onto exp_q; a negedge monitor pops one entry for every new
//   grant edge (BGn or a GNTn bit falling) and also watches the invariants.
module tb_u110_bus_arbiter;
  localparam int NREQ = 2;
  localparam int GT   = 16;
  localparam int MT   = 64;
  localparam logic [NREQ-1:0] ALL1 = {NREQ{1'b1}};

  logic            CLK40 = 1'b0;
  logic            RESETn;
  logic            BRn;
  logic            BBn;
  logic [NREQ-1:0] REQn;
  logic            BGn;
  logic [NREQ-1:0] GNTn;
  logic [2:0]      OWNER;
  logic            ARB_TIMEOUT;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  u110_bus_arbiter #(.NREQ(NREQ), .GRANT_TIMEOUT(GT), .MAX_TENURE(MT)) dut (
    .CLK40(CLK40), .RESETn(RESETn), .BRn(BRn), .BBn(BBn), .REQn(REQn),
    .BGn(BGn), .GNTn(GNTn), .OWNER(OWNER), .ARB_TIMEOUT(ARB_TIMEOUT)
  );

  always #10 CLK40 = ~CLK40;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // grant-order scoreboard and invariant monitor
  logic            prev_bgn = 1'b0;
  logic [NREQ-1:0] prev_gntn = ALL1;
  logic            prev_bbn = 1'b1;
  int              ev;
  int              e;
  int              ones;

  always @(negedge CLK40) begin
    if (!RESETn) begin
      prev_bgn  = 1'b0;
      prev_gntn = ALL1;
    end else begin
      ones = 0;
      for (int k = 0; k < NREQ; k++) if (!GNTn[k]) ones++;
      checks++;
      if (ones > 1 || (!BGn && ones != 0)) begin
        errors++;
        $display("FAIL grant_exclusive: BGn=%b GNTn=%b, required at most one grant", BGn, GNTn);
      end
      ev = -1;
      if (prev_bgn && !BGn) ev = 0;
      for (int k = 0; k < NREQ; k++) if (prev_gntn[k] && !GNTn[k]) ev = k + 1;
      if (ev >= 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_order: unexpected grant to %0d, none expected", ev);
        end else begin
          e = exp_q.pop_front();
          if (ev != e || OWNER !== 3'(e) || (ev > 0 && !prev_bbn)) begin
            errors++;
            $display("FAIL grant_order: granted %0d OWNER=%0d prev_BBn=%b, required %0d with BBn idle",
                     ev, OWNER, prev_bbn, e);
          end
        end
      end
      prev_bgn  = BGn;
      prev_gntn = GNTn;
    end
    prev_bbn = BBn;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK40);
    #1;
  endtask

  task automatic wait_grant(input int limit, output bit ok);
    int i = 0;
    while (i < limit && GNTn === ALL1) begin
      tick(1);
      i++;
    end
    ok = (GNTn !== ALL1);
  endtask

  task automatic wait_park(input int limit, output bit ok);
    int i = 0;
    while (i < limit && BGn !== 1'b0) begin
      tick(1);
      i++;
    end
    ok = (BGn === 1'b0);
  endtask

  task automatic do_reset;
    @(posedge CLK40);
    #3;
    RESETn = 1'b0;
    BRn = 1'b1; BBn = 1'b1; REQn = ALL1;
    #20;
    RESETn = 1'b1;
    tick(1);
  endtask

  task automatic test_reset;
    int bad = 0;
    RESETn = 1'b0; BRn = 1'b1; BBn = 1'b1; REQn = ALL1;
    #25;
    checks++;
    if (BGn !== 1'b0 || GNTn !== ALL1 || OWNER !== 3'd0 || ARB_TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: BGn=%b GNTn=%b OWNER=%0d TO=%b, required 0 11 0 0",
               BGn, GNTn, OWNER, ARB_TIMEOUT);
    end
    @(posedge CLK40);
    #3;
    RESETn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (BGn !== 1'b0 || GNTn !== ALL1 || OWNER !== 3'd0 || ARB_TIMEOUT !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_handoff;
    BBn = 1'b0;
    REQn = 2'b10;
    tick(1);
    checks++;
    if (BGn !== 1'b1) begin
      errors++;
      $display("FAIL handoff_bg_release: BGn=%b, required 1", BGn);
    end
    tick(3);
    checks++;
    if (GNTn !== ALL1 || BGn !== 1'b1) begin
      errors++;
      $display("FAIL handoff_wait_bb: GNTn=%b BGn=%b, required 11 1", GNTn, BGn);
    end
    exp_q.push_back(1);
    BBn = 1'b1;
    tick(1);
    checks++;
    if (GNTn !== 2'b10 || OWNER !== 3'd1) begin
      errors++;
      $display("FAIL handoff_grant: GNTn=%b OWNER=%0d, required 10 1", GNTn, OWNER);
    end
    BBn = 1'b0;
    tick(4);
    REQn = ALL1;
    tick(1);
    checks++;
    if (GNTn !== ALL1 || BGn !== 1'b1) begin
      errors++;
      $display("FAIL handoff_release: GNTn=%b BGn=%b, required 11 1", GNTn, BGn);
    end
    tick(2);
    exp_q.push_back(0);
    BBn = 1'b1;
    tick(1);
    checks++;
    if (BGn !== 1'b0 || OWNER !== 3'd0) begin
      errors++;
      $display("FAIL handoff_park: BGn=%b OWNER=%0d, required 0 0", BGn, OWNER);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int exp_w;
    do_reset();
    exp_w = 0;
    BRn = 1'b1; BBn = 1'b1; REQn = '0;
    exp_q.push_back(exp_w + 1);
    for (int t = 0; t < 4; t++) begin
      wait_grant(10, ok);
      checks++;
      if (!ok || OWNER !== 3'(exp_w + 1) || GNTn !== ~(NREQ'(1) << exp_w)) begin
        errors++;
        $display("FAIL rr_grant_%0d: GNTn=%b OWNER=%0d, required master %0d", t, GNTn, OWNER, exp_w);
      end
      BBn = 1'b0;
      tick(3);
      if (t < 3) begin
        REQn[exp_w] = 1'b1;
        exp_w = (exp_w + 1) % NREQ;
        exp_q.push_back(exp_w + 1);
      end else begin
        REQn = ALL1;
        exp_q.push_back(0);
      end
      BBn = 1'b1;
      tick(1);
      checks++;
      if (GNTn !== ALL1) begin
        errors++;
        $display("FAIL rr_release_%0d: GNTn=%b, required 11", t, GNTn);
      end
      if (t < 3) REQn = '0;
    end
    wait_park(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_park: BGn=%b, required 0", BGn);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n = 0;
    int pulses = 0;
    REQn = 2'b01;
    exp_q.push_back(2);
    wait_grant(10, ok);
    checks++;
    if (!ok || GNTn !== 2'b01 || OWNER !== 3'd2) begin
      errors++;
      $display("FAIL to_grant: GNTn=%b OWNER=%0d, required 01 2", GNTn, OWNER);
    end
    while (n < 40 && GNTn !== ALL1) begin
      tick(1);
      n++;
      if (ARB_TIMEOUT === 1'b1) pulses++;
    end
    REQn = ALL1;
    exp_q.push_back(0);
    tick(1);
    if (ARB_TIMEOUT === 1'b1) pulses++;
    checks++;
    if (n != GT) begin
      errors++;
      $display("FAIL to_cycles: grant held %0d cycles, required %0d", n, GT);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL to_pulse: %0d pulses, required 1", pulses);
    end
    checks++;
    if (BGn !== 1'b0) begin
      errors++;
      $display("FAIL to_park: BGn=%b, required 0", BGn);
    end
  endtask

  task automatic test_timeout_withdraw;
    bit ok;
    REQn = 2'b01;
    exp_q.push_back(2);
    wait_grant(10, ok);
    tick(GT - 1);
    checks++;
    if (!ok || GNTn !== 2'b01 || ARB_TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL tow_before: GNTn=%b TO=%b, required 01 0", GNTn, ARB_TIMEOUT);
    end
    REQn = ALL1;
    tick(1);
    checks++;
    if (GNTn !== ALL1 || ARB_TIMEOUT !== 1'b1) begin
      errors++;
      $display("FAIL tow_pulse: GNTn=%b TO=%b, required 11 1", GNTn, ARB_TIMEOUT);
    end
    exp_q.push_back(0);
    tick(1);
    checks++;
    if (BGn !== 1'b0 || ARB_TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL tow_park: BGn=%b TO=%b, required 0 0", BGn, ARB_TIMEOUT);
    end
  endtask

  task automatic test_tenure;
    bit ok;
    int n = 0;
    BRn = 1'b1; BBn = 1'b1; REQn = 2'b10;
    exp_q.push_back(1);
    wait_grant(10, ok);
    checks++;
    if (!ok || GNTn !== 2'b10) begin
      errors++;
      $display("FAIL ten_grant: GNTn=%b, required 10", GNTn);
    end
    BBn = 1'b0;
    BRn = 1'b0;
    tick(1);
    // edges counted from entry into ownership
    while (n < 100 && GNTn[0] !== 1'b1) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != MT || BGn !== 1'b1) begin
      errors++;
      $display("FAIL ten_preempt: released after %0d cycles BGn=%b, required %0d 1", n, BGn, MT);
    end
    exp_q.push_back(0);
    exp_q.push_back(1);
    BBn = 1'b1;
    tick(1);
    checks++;
    if (BGn !== 1'b0 || OWNER !== 3'd0 || GNTn !== ALL1) begin
      errors++;
      $display("FAIL ten_cpu_turn: BGn=%b OWNER=%0d GNTn=%b, required 0 0 11", BGn, OWNER, GNTn);
    end
    BRn = 1'b1;
    wait_grant(10, ok);
    checks++;
    if (!ok || OWNER !== 3'd1) begin
      errors++;
      $display("FAIL ten_regrant: GNTn=%b OWNER=%0d, required 10 1", GNTn, OWNER);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    BBn = 1'b0;
    tick(4);
    #3;
    RESETn = 1'b0;
    #1;
    checks++;
    if (GNTn !== ALL1 || BGn !== 1'b0 || OWNER !== 3'd0 || ARB_TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: GNTn=%b BGn=%b OWNER=%0d, required 11 0 0", GNTn, BGn, OWNER);
    end
    BBn = 1'b1; BRn = 1'b1; REQn = ALL1;
    tick(2);
    RESETn = 1'b1;
    REQn = '0;
    exp_q.push_back(1);
    wait_grant(10, ok);
    checks++;
    if (!ok || GNTn !== 2'b10 || OWNER !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_rr: GNTn=%b OWNER=%0d, required 10 1", GNTn, OWNER);
    end
    REQn = ALL1;
    exp_q.push_back(0);
    wait_park(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_park: BGn=%b, required 0", BGn);
    end
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_round_robin();
    test_timeout();
    test_timeout_withdraw();
    test_tenure();
    test_reset_mid();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
